// File: rtl/reg_arb_pkg.sv
// Shared types for the two-port register-bus arbiter: FSM states, requester IDs
// and the one-entry request slot.
package reg_arb_pkg;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 8;
    localparam int RD_LAT_MAX = 3;
    localparam int LAT_CNT_W  = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

    typedef enum logic {REQ_A, REQ_B} req_id_t;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } req_slot_t;

    function automatic req_id_t other_port(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_slot.sv
// One-entry holding slot for a strobe-based requester: captures a strobe,
// frees when issued (reloading on the same edge if needed) and flags drops.
module req_slot
    import reg_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ARB_ADDR_W-1:0] addr,
    input  logic [ARB_DATA_W-1:0] wdata,
    input  logic                  issue,
    input  logic                  err_clr,
    output req_slot_t             slot,
    output logic                  err
);

    logic strobe;
    logic can_load;
    logic err_set;

    // wr+rd together still loads the write; only the read is lost
    always_comb begin
        strobe   = wr | rd;
        can_load = ~slot.valid | issue;
        err_set  = (wr & rd) | (strobe & ~can_load);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
            err  <= 1'b0;
        end else begin
            if (strobe && can_load) begin
                slot <= '{valid: 1'b1, we: wr, addr: addr, wdata: wdata};
            end else if (issue) begin
                slot.valid <= 1'b0;
            end
            if (err_clr) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the register-file port between the I2C (A) and
// SPI (B) slaves; returns read data to the requesting port.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_wr,
    input  logic              a_rd,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    output logic              a_busy,
    input  logic              b_wr,
    input  logic              b_rd,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              b_busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wr,
    output logic              rf_rd,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              err_clr,
    output logic              err_a,
    output logic              err_b
);

    if (RD_LATENCY < 1 || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $fatal(1, "reg_bus_arbiter: RD_LATENCY %0d outside 1..%0d", RD_LATENCY, RD_LAT_MAX);
    end
    if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W) begin : g_bad_width
        $fatal(1, "reg_bus_arbiter: ADDR_W/DATA_W must match the slot widths in reg_arb_pkg");
    end

    arb_state_t            state, state_n;
    req_id_t               last, last_n, owner, owner_n, pick;
    logic                  cur_we, we_n;
    logic [LAT_CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0]     addr_n;
    logic [DATA_W-1:0]     wdata_n, a_rdata_n, b_rdata_n;
    logic                  wr_n, rd_n, a_rvalid_n, b_rvalid_n;
    logic                  issue_a, issue_b;
    req_slot_t             slot_a, slot_b, sel;

    req_slot u_slot_a (
        .clk(clk), .rst(rst), .wr(a_wr), .rd(a_rd), .addr(a_addr), .wdata(a_wdata),
        .issue(issue_a), .err_clr(err_clr), .slot(slot_a), .err(err_a)
    );

    req_slot u_slot_b (
        .clk(clk), .rst(rst), .wr(b_wr), .rd(b_rd), .addr(b_addr), .wdata(b_wdata),
        .issue(issue_b), .err_clr(err_clr), .slot(slot_b), .err(err_b)
    );

    // A read stays outstanding for its owner until the rvalid edge returns to IDLE
    assign a_busy = slot_a.valid | ((state != IDLE) & ~cur_we & (owner == REQ_A));
    assign b_busy = slot_b.valid | ((state != IDLE) & ~cur_we & (owner == REQ_B));

    always_comb begin
        state_n    = state;
        last_n     = last;
        owner_n    = owner;
        we_n       = cur_we;
        cnt_n      = cnt;
        addr_n     = rf_addr;
        wdata_n    = rf_wdata;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        a_rdata_n  = a_rdata;
        b_rdata_n  = b_rdata;
        a_rvalid_n = 1'b0;
        b_rvalid_n = 1'b0;
        issue_a    = 1'b0;
        issue_b    = 1'b0;

        pick = REQ_A;
        if (slot_a.valid && slot_b.valid) begin
            pick = other_port(last);
        end else if (slot_b.valid) begin
            pick = REQ_B;
        end
        sel = (pick == REQ_A) ? slot_a : slot_b;

        case (state)
            IDLE: begin
                if (slot_a.valid || slot_b.valid) begin
                    addr_n  = sel.addr;
                    if (sel.we) begin
                        wdata_n = sel.wdata;
                    end
                    wr_n    = sel.we;
                    rd_n    = ~sel.we;
                    we_n    = sel.we;
                    owner_n = pick;
                    last_n  = pick;
                    issue_a = (pick == REQ_A);
                    issue_b = (pick == REQ_B);
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_we) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = LAT_CNT_W'(RD_LATENCY);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == LAT_CNT_W'(1)) begin
                    if (owner == REQ_A) begin
                        a_rdata_n  = rf_rdata;
                        a_rvalid_n = 1'b1;
                    end else begin
                        b_rdata_n  = rf_rdata;
                        b_rvalid_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= REQ_B;
            owner    <= REQ_A;
            cur_we   <= 1'b0;
            cnt      <= '0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            rf_wr    <= 1'b0;
            rf_rd    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            owner    <= owner_n;
            cur_we   <= we_n;
            cnt      <= cnt_n;
            rf_addr  <= addr_n;
            rf_wdata <= wdata_n;
            rf_wr    <= wr_n;
            rf_rd    <= rd_n;
            a_rdata  <= a_rdata_n;
            b_rdata  <= b_rdata_n;
            a_rvalid <= a_rvalid_n;
            b_rvalid <= b_rvalid_n;
        end
    end

endmodule
